// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
//   Shared definitions for the WS2812 frame driver: default bit/latch timing
//   in CLOCK_50 cycles, the colour word width, the cycle counter width and
//   the frame FSM state type.
// ---------------------------------------------------------------------------
package ws2812_pkg;

  // GRB colour word, sent MSB first
  localparam int GRB_W = 24;

  // Default WS2812 timing at 50 MHz (20 ns per cycle)
  localparam int DEF_T0H       = 20;    // 400 ns
  localparam int DEF_T0L       = 43;    // 860 ns
  localparam int DEF_T1H       = 40;    // 800 ns
  localparam int DEF_T1L       = 23;    // 460 ns
  localparam int DEF_RESET_CYC = 2600;  // 52 us latch gap

  // Segment cycle counter width; holds the longest segment (the latch gap)
  localparam int CYC_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    LATCH
  } fsm_t;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// ---------------------------------------------------------------------------
// ws2812_bit_encoder
//   Times one waveform segment at a time for the frame FSM. The current
//   segment is the FSM state: HIGH and LOW last T1x/T0x cycles depending on
//   bit_val, LATCH lasts RESET_CYC cycles. Owns the segment cycle counter and
//   the registered serial output.
// Ports
//   clk       in   clock
//   reset     in   synchronous, active-high
//   start     in   restart the cycle counter (FSM changes state this cycle)
//   seg       in   current segment (FSM state)
//   bit_val   in   value of the bit being sent
//   seg_done  out  last cycle of the current timed segment
//   bit_done  out  last cycle of a bit's low phase
//   led_dout  out  registered serial data, high while the FSM was in HIGH
// ---------------------------------------------------------------------------
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int T0H       = DEF_T0H,
  parameter int T0L       = DEF_T0L,
  parameter int T1H       = DEF_T1H,
  parameter int T1L       = DEF_T1L,
  parameter int RESET_CYC = DEF_RESET_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  fsm_t seg,
  input  logic bit_val,
  output logic seg_done,
  output logic bit_done,
  output logic led_dout
);

  logic [CYC_W-1:0] cyc_cnt;
  logic [CYC_W-1:0] seg_len;

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    seg_len = CYC_W'(1);
    case (seg)
      HIGH:    seg_len = bit_val ? CYC_W'(T1H) : CYC_W'(T0H);
      LOW:     seg_len = bit_val ? CYC_W'(T1L) : CYC_W'(T0L);
      LATCH:   seg_len = CYC_W'(RESET_CYC);
      default: seg_len = CYC_W'(1);
    endcase
  end

  assign seg_done = (cyc_cnt == seg_len - 1'b1);
  assign bit_done = seg_done && (seg == LOW);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt  <= '0;
      led_dout <= 1'b0;
    end else begin
      // Saturate rather than wrap so a long IDLE never aliases a segment end
      if (start) begin
        cyc_cnt <= '0;
      end else if (cyc_cnt != '1) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
      // One cycle behind the FSM: led_dout rises the cycle after HIGH starts
      led_dout <= (seg == HIGH);
    end
  end

endmodule

// File: rtl/led_frame_driver.sv
// ---------------------------------------------------------------------------
// led_frame_driver
//   Snapshots a ROWS x COLS on/off pixel matrix on request and serialises it
//   to a WS2812 strip: lit pixels as ON_COLOR, dark pixels as 24'h0, row 0
//   first, each word MSB first, followed by a low latch gap. One request may
//   be held while a frame is in flight; further requests merge into it.
//   Build option: define SERPENTINE_EN to send odd rows right-to-left for a
//   zig-zag wired strip. Timing is the same either way.
// Ports
//   CLOCK_50    in   50 MHz clock
//   reset       in   synchronous, active-high
//   state_in    in   pixel matrix, pixel (r,c) = state_in[r*COLS+c]
//   frame_req   in   single-cycle request to send state_in
//   busy        out  high whenever the FSM is not IDLE
//   frame_done  out  one-cycle pulse on the last latch cycle after a frame
//   led_dout    out  registered serial data to the strip
// ---------------------------------------------------------------------------
module led_frame_driver
  import ws2812_pkg::*;
#(
  parameter int               ROWS      = 12,
  parameter int               COLS      = 16,
  parameter logic [GRB_W-1:0] ON_COLOR  = 24'h00FF00,
  parameter int               T0H       = DEF_T0H,
  parameter int               T0L       = DEF_T0L,
  parameter int               T1H       = DEF_T1H,
  parameter int               T1L       = DEF_T1L,
  parameter int               RESET_CYC = DEF_RESET_CYC
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] state_in,
  input  logic                 frame_req,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 led_dout
);

  localparam int               NPIX     = ROWS * COLS;
  localparam int               PIX_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);
  localparam logic [4:0]       LAST_BIT = 5'(GRB_W - 1);

  fsm_t             state;
  fsm_t             next_state;
  logic [NPIX-1:0]  stream_in;   // state_in reordered into transmit order
  logic [NPIX-1:0]  snap;        // frame being sent, in transmit order
  logic [PIX_W-1:0] pix_cnt;
  logic [PIX_W-1:0] pix_next;
  logic [4:0]       bit_cnt;
  logic [GRB_W-1:0] shift_word;
  logic             pending;     // one held request
  logic             frame_sent;  // current LATCH closes a frame
  logic             seg_done;
  logic             bit_done;
  logic             start;

  // Stream index p = r*COLS + c picks matrix column src_c of row r
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
`ifdef SERPENTINE_EN
      localparam int SRC_C = (r % 2 == 1) ? (COLS - 1 - c) : c;
`else
      localparam int SRC_C = c;
`endif
      assign stream_in[r*COLS + c] = state_in[r*COLS + SRC_C];
    end
  end

  assign pix_next = pix_cnt + 1'b1;
  assign start    = (next_state != state);

  ws2812_bit_encoder #(
    .T0H       (T0H),
    .T0L       (T0L),
    .T1H       (T1H),
    .T1L       (T1L),
    .RESET_CYC (RESET_CYC)
  ) u_encoder (
    .clk      (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .seg      (state),
    .bit_val  (shift_word[GRB_W-1]),
    .seg_done (seg_done),
    .bit_done (bit_done),
    .led_dout (led_dout)
  );

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    case (state)
      IDLE:  if (frame_req) next_state = LOAD;
      LOAD:  next_state = HIGH;
      HIGH:  if (seg_done) next_state = LOW;
      LOW: begin
        if (bit_done) begin
          next_state = (bit_cnt == LAST_BIT && pix_cnt == LAST_PIX) ? LATCH : HIGH;
        end
      end
      LATCH: begin
        if (seg_done) begin
          // A request arriving on the final latch cycle is honoured directly
          next_state = (pending || frame_req) ? LOAD : IDLE;
          frame_done = frame_sent;
        end
      end
      default: next_state = LATCH;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= LATCH;
      pending    <= 1'b0;
      frame_sent <= 1'b0;
      pix_cnt    <= '0;
      bit_cnt    <= '0;
      shift_word <= '0;
    end else begin
      state <= next_state;

      if (next_state == LOAD) begin
        pending <= 1'b0;
      end else if (frame_req && state != IDLE) begin
        pending <= 1'b1;
      end

      if (state == LOW && next_state == LATCH) begin
        frame_sent <= 1'b1;
      end else if (state == LATCH && next_state != LATCH) begin
        frame_sent <= 1'b0;
      end

      case (state)
        LOAD: begin
          pix_cnt    <= '0;
          bit_cnt    <= '0;
          shift_word <= stream_in[0] ? ON_COLOR : '0;
        end
        LOW: begin
          if (bit_done) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              pix_cnt    <= pix_next;
              shift_word <= snap[pix_next] ? ON_COLOR : '0;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              shift_word <= {shift_word[GRB_W-2:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: snap is pure datapath with no reset; LOAD always writes it before
  // any bit of it is transmitted.
  always_ff @(posedge CLOCK_50) begin
    if (state == LOAD) begin
      snap <= stream_in;
    end
  end

endmodule

// File: tb/tb_led_frame_driver.sv
// ---------------------------------------------------------------------------
// tb_led_frame_driver
//   Bench for led_frame_driver with a reduced matrix (2 x 16) and shortened
//   bit/latch timing. Expected bits are queued when a frame is requested; a
//   negedge monitor decodes high/low run lengths of led_dout and compares
//   each decoded bit against the queue head.
// ---------------------------------------------------------------------------
module tb_led_frame_driver;

  localparam int          ROWS     = 2;
  localparam int          COLS     = 16;
  localparam int          NPIX     = ROWS * COLS;
  localparam logic [23:0] ON_COLOR = 24'h00FF00;
  localparam int          T0H      = 2;
  localparam int          T0L      = 5;
  localparam int          T1H      = 4;
  localparam int          T1L      = 3;
  localparam int          RST      = 40;
  localparam int          BIT_CYC  = 7;
  localparam int          PIX_CYC  = 24 * BIT_CYC;
  localparam int          FRAME    = NPIX * PIX_CYC;
  // Ticks from the request-drive cycle: LOAD is tick 1, data ticks 2..FRAME+1
  localparam int          FIRST_RISE = 3;
  localparam int          DONE_N     = FRAME + RST + 1;
  localparam int          GAP_N      = FRAME + RST + 1;
`ifdef SERPENTINE_EN
  localparam int          EXP_LIT    = 31;
`else
  localparam int          EXP_LIT    = 16;
`endif

  logic            CLOCK_50  = 1'b0;
  logic            reset     = 1'b1;
  logic [NPIX-1:0] state_in  = '0;
  logic            frame_req = 1'b0;
  logic            busy;
  logic            frame_done;
  logic            led_dout;

  always #10 CLOCK_50 = ~CLOCK_50;

  led_frame_driver #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .ON_COLOR  (ON_COLOR),
    .T0H       (T0H),
    .T0L       (T0L),
    .T1H       (T1H),
    .T1L       (T1L),
    .RESET_CYC (RST)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .state_in   (state_in),
    .frame_req  (frame_req),
    .busy       (busy),
    .frame_done (frame_done),
    .led_dout   (led_dout)
  );

  typedef struct {
    int high;
    int low;
    bit last;
  } bit_exp_t;

  bit_exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // monitor state
  int lit_first = -1;
  int bit_idx   = 0;
  int hi_len    = 0;
  int lo_len    = 0;
  bit in_bit    = 1'b0;
  bit prev_led  = 1'b0;

  function automatic int src_index(input int p);
    int r;
    int c;
    r = p / COLS;
    c = p % COLS;
`ifdef SERPENTINE_EN
    if (r % 2 == 1) c = COLS - 1 - c;
`endif
    return r * COLS + c;
  endfunction

  function automatic void push_frame(input logic [NPIX-1:0] pix);
    for (int p = 0; p < NPIX; p++) begin
      logic [23:0] word;
      word = pix[src_index(p)] ? ON_COLOR : 24'h0;
      for (int b = 23; b >= 0; b--) begin
        bit_exp_t e;
        e.high = word[b] ? T1H : T0H;
        e.low  = word[b] ? T1L : T0L;
        e.last = (p == NPIX - 1) && (b == 0);
        sb.push_back(e);
      end
    end
  endfunction

  task automatic complete_bit(input bit by_done);
    bit_exp_t e;
    int exp_low;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL bit_unexpected idx=%0d got high=%0d low=%0d, none expected",
               bit_idx, hi_len, lo_len);
    end else begin
      e = sb.pop_front();
      // The last bit's low run continues through the latch gap to frame_done
      exp_low = e.last ? e.low + RST - 1 : e.low;
      if (hi_len !== e.high || lo_len !== exp_low || by_done !== e.last) begin
        bad++;
        $display("FAIL bit_timing idx=%0d got high=%0d low=%0d end=%0d want high=%0d low=%0d end=%0d",
                 bit_idx, hi_len, lo_len, by_done, e.high, exp_low, e.last);
      end
    end
    if (hi_len == T1H && lit_first < 0) lit_first = bit_idx / 24;
    bit_idx++;
  endtask

  // Decode led_dout run lengths, sampled mid-cycle
  always @(negedge CLOCK_50) begin
    if (reset) begin
      in_bit   = 1'b0;
      prev_led = 1'b0;
      bit_idx  = 0;
    end else begin
      if (led_dout === 1'b1) begin
        if (!prev_led) begin
          if (in_bit) complete_bit(1'b0);
          in_bit = 1'b1;
          hi_len = 1;
          lo_len = 0;
        end else begin
          hi_len++;
        end
      end else if (in_bit) begin
        lo_len++;
      end
      prev_led = (led_dout === 1'b1);
      if (frame_done === 1'b1 && in_bit) begin
        complete_bit(1'b1);
        in_bit  = 1'b0;
        bit_idx = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  // Called on the cycle reset is released: latch gap then IDLE
  task automatic check_post_reset(input string tag);
    int errs = 0;
    for (int i = 1; i < RST; i++) begin
      tick();
      if (busy !== 1'b1 || led_dout !== 1'b0 || frame_done !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s_latch_hold got %0d bad cycles, want 0", tag, errs);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle got busy=%b want 0", tag, busy);
    end
  endtask

  task automatic run_frame(input logic [NPIX-1:0] pix, output int rise_n, output int done_n);
    state_in  = pix;
    push_frame(pix);
    lit_first = -1;
    frame_req = 1'b1;
    rise_n    = -1;
    done_n    = -1;
    for (int n = 1; n <= DONE_N + 100; n++) begin
      tick();
      if (n == 1) frame_req = 1'b0;
      if (rise_n < 0 && led_dout === 1'b1) rise_n = n;
      if (frame_done === 1'b1) begin
        done_n = n;
        break;
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if ({busy, led_dout, frame_done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_values got busy/led/done=%b%b%b want 100", busy, led_dout, frame_done);
    end
    reset = 1'b0;
    check_post_reset("reset");
  endtask

  task automatic test_single_pixel();
    int rise_n;
    int done_n;
    run_frame(NPIX'(1), rise_n, done_n);
    check_int("first_rise", rise_n, FIRST_RISE);
    check_int("frame_done_time", done_n, DONE_N);
    tick();
    check_int("single_sb_drained", sb.size(), 0);
    check_int("single_lit_pixel", lit_first, 0);
    check_int("single_idle_after", int'(busy), 0);
  endtask

  task automatic test_pending();
    logic [NPIX-1:0] pat;
    int d1 = -1;
    int d2 = -1;
    int gaps = 0;
    int errs = 0;
    pat       = 32'h8421_F00D;
    state_in  = pat;
    push_frame(pat);
    frame_req = 1'b1;
    for (int n = 1; n <= 2 * DONE_N + 100; n++) begin
      tick();
      frame_req = (n == 400 || n == 900);
      if (n == 400) push_frame(pat);
      if (busy !== 1'b1) gaps++;
      if (frame_done === 1'b1) begin
        if (d1 < 0) d1 = n;
        else begin
          d2 = n;
          break;
        end
      end
    end
    check_int("pending_first_done", d1, DONE_N);
    check_int("pending_second_gap", (d2 < 0) ? -1 : d2 - d1, GAP_N);
    check_int("pending_busy_gaps", gaps, 0);
    tick();
    check_int("pending_idle_after", int'(busy), 0);
    repeat (50) begin
      tick();
      if (busy !== 1'b0 || frame_done !== 1'b0) errs++;
    end
    check_int("pending_no_third", errs, 0);
    check_int("pending_sb_drained", sb.size(), 0);
  endtask

  task automatic test_snapshot_back_to_back();
    logic [NPIX-1:0] pat;
    int d1 = -1;
    int d2 = -1;
    int gaps = 0;
    pat       = 32'h0F0F_3C21;
    state_in  = pat;
    push_frame(pat);
    frame_req = 1'b1;
    for (int n = 1; n <= 2 * DONE_N + 100; n++) begin
      tick();
      frame_req = 1'b0;
      if (n == 2 + 5 * PIX_CYC + 40) state_in = '1;  // mid pixel 5
      if (busy !== 1'b1) gaps++;
      if (frame_done === 1'b1) begin
        if (d1 < 0) begin
          d1 = n;
          push_frame('1);
          frame_req = 1'b1;  // on the final latch cycle
        end else begin
          d2 = n;
          break;
        end
      end
    end
    check_int("b2b_first_done", d1, DONE_N);
    check_int("b2b_second_gap", (d2 < 0) ? -1 : d2 - d1, GAP_N);
    check_int("b2b_busy_gaps", gaps, 0);
    tick();
    check_int("b2b_sb_drained", sb.size(), 0);
    check_int("b2b_idle_after", int'(busy), 0);
  endtask

  task automatic test_mid_frame_reset();
    logic [NPIX-1:0] pat;
    int errs = 0;
    pat       = 32'hDEAD_BEEF;
    state_in  = pat;
    push_frame(pat);
    frame_req = 1'b1;
    // Stop on the second HIGH cycle of a bit in pixel 20, led_dout high
    for (int n = 1; n <= 2 + 20 * PIX_CYC + 5 * BIT_CYC + 1; n++) begin
      tick();
      frame_req = (n == 300);
    end
    check_int("mid_reset_led_before", int'(led_dout), 1);
    reset = 1'b1;
    tick();
    total++;
    if ({busy, led_dout, frame_done} !== 3'b100) begin
      bad++;
      $display("FAIL mid_reset_values got busy/led/done=%b%b%b want 100", busy, led_dout, frame_done);
    end
    reset = 1'b0;
    sb.delete();
    check_post_reset("mid_reset");
    repeat (40) begin
      tick();
      if (busy !== 1'b0 || frame_done !== 1'b0) errs++;
    end
    check_int("mid_reset_pending_dropped", errs, 0);
  endtask

  task automatic test_mapping();
    logic [NPIX-1:0] pix;
    int rise_n;
    int done_n;
    pix = '0;
    pix[16] = 1'b1;  // pixel (r=1, c=0)
    run_frame(pix, rise_n, done_n);
    check_int("map_frame_done_time", done_n, DONE_N);
    tick();
    check_int("map_lit_stream_pixel", lit_first, EXP_LIT);
    check_int("map_sb_drained", sb.size(), 0);
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_pending();
    test_snapshot_back_to_back();
    test_mid_frame_reset();
    test_mapping();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
